// File: rtl/if_fetch_pkg.sv
// Shared types and helpers for the IF fetch controller.
// Widths, FSM states and the packet word-count helper.
package if_fetch_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 128;
  localparam int WORDS_PER_PKT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // A fetch starting mid-packet only yields the words up to the 16B boundary.
  function automatic logic [2:0] calc_fetch_cnt(
    input logic [1:0] word_idx
  );
    return 3'(WORDS_PER_PKT) - {1'b0, word_idx};
  endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// Small synchronous FIFO with a one-cycle clear.
// Used for the in-flight PC queue and the fetch packet buffer.
module fetch_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push)
                     - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; only entries behind valid pointers are read.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  a_pop_empty: assert property (
    @(posedge clk) disable iff (rst)
    !(pop && empty)
  );

  a_push_full: assert property (
    @(posedge clk) disable iff (rst)
    !(push && full && !pop)
  );

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer between the IF PC register and the icache.
// Credit-limited issue, in-order response pairing, redirect drain.
module if_fetch_ctrl
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_OUTST = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              icache_req,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_addr_ok,
  input  logic              icache_data_ok,
  input  logic [DATA_W-1:0] icache_rdata,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [DATA_W-1:0] fetch_data,
  output logic [2:0]        fetch_cnt
);

  localparam int CW    = $clog2(MAX_OUTST) + 1;
  localparam int CSW   = CW + 1;
  localparam int QCW   = $clog2(MAX_OUTST + 1);
  localparam int BCW   = $clog2(BUF_DEPTH + 1);
  localparam int PKT_W = ADDR_W + DATA_W;

  fetch_state_e      state;
  logic [CW-1:0]     outst_cnt;
  logic [CW-1:0]     cancel_cnt;
  logic [CW-1:0]     outst_nx;
  logic [CSW-1:0]    cancel_sum;

  logic              drain;
  logic              can_issue;
  logic              hs;
  logic              resp_ok;
  logic              buf_pop;

  logic [ADDR_W-1:0] pcq_head;
  logic              pcq_full;
  logic              pcq_empty;
  logic [QCW-1:0]    pcq_count;

  logic [PKT_W-1:0]  buf_head;
  logic              buf_full;
  logic              buf_empty;
  logic [BCW-1:0]    buf_count;

  assign drain = (state == DRAIN);

  // Buffer credit: every accepted request already owns a packet slot.
  assign can_issue =
    (int'(outst_cnt) < MAX_OUTST) &&
    (int'(outst_cnt) + int'(buf_count) < BUF_DEPTH);

  assign icache_req = !rst_ && pc_valid && !flush
                   && !drain && can_issue;
  assign icache_addr = pc_in;
  assign hs          = icache_req && icache_addr_ok;
  assign pc_ready    = hs;

  assign resp_ok  = icache_data_ok && !flush && !drain;
  assign outst_nx = outst_cnt + CW'(hs) - CW'(resp_ok);

  assign cancel_sum = {1'b0, cancel_cnt}
                    + {1'b0, outst_cnt}
                    - CSW'(icache_data_ok);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state      <= IDLE;
      outst_cnt  <= '0;
      cancel_cnt <= '0;
    end else if (flush) begin
      outst_cnt  <= '0;
      cancel_cnt <= cancel_sum[CW-1:0];
      state      <= (cancel_sum != '0) ? DRAIN : IDLE;
    end else if (drain) begin
      if (icache_data_ok) begin
        cancel_cnt <= cancel_cnt - CW'(1);
        if (cancel_cnt == CW'(1)) state <= IDLE;
      end
    end else begin
      outst_cnt <= outst_nx;
      state     <= (outst_nx != '0) ? BUSY : IDLE;
    end
  end

  fetch_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTST)
  ) u_pc_q (
    .clk   (clk),
    .rst   (rst_),
    .push  (hs),
    .pop   (resp_ok),
    .clear (flush),
    .din   (pc_in),
    .dout  (pcq_head),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

  assign buf_pop = fetch_valid && fetch_ready;

  fetch_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (BUF_DEPTH)
  ) u_pkt_buf (
    .clk   (clk),
    .rst   (rst_),
    .push  (resp_ok),
    .pop   (buf_pop),
    .clear (flush),
    .din   ({pcq_head, icache_rdata}),
    .dout  (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign fetch_valid = !buf_empty;
  assign fetch_pc    = buf_empty ? '0
                     : buf_head[PKT_W-1 -: ADDR_W];
  assign fetch_data  = buf_empty ? '0
                     : buf_head[DATA_W-1:0];
  assign fetch_cnt   = calc_fetch_cnt(fetch_pc[3:2]);

  a_orphan_resp: assert property (
    @(posedge clk) disable iff (rst_)
    !(icache_data_ok && outst_cnt == '0
      && cancel_cnt == '0)
  );

  a_cancel_max: assert property (
    @(posedge clk) disable iff (rst_)
    cancel_cnt <= CW'(MAX_OUTST)
  );

  a_cancel_sum: assert property (
    @(posedge clk) disable iff (rst_)
    flush |-> cancel_sum <= CSW'(MAX_OUTST)
  );

  a_pcq_track: assert property (
    @(posedge clk) disable iff (rst_)
    int'(pcq_count) == int'(outst_cnt)
  );

  a_pcq_room: assert property (
    @(posedge clk) disable iff (rst_)
    !(hs && pcq_full)
  );

  a_resp_pc: assert property (
    @(posedge clk) disable iff (rst_)
    !(resp_ok && pcq_empty)
  );

  a_credit: assert property (
    @(posedge clk) disable iff (rst_)
    !(resp_ok && buf_full && !buf_pop)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed redirect/reset scenarios
// followed by random traffic against a queue-based reference.
module tb_if_fetch_ctrl;
  import if_fetch_pkg::*;

  localparam int MO = 2;
  localparam int BD = 2;

  logic         clk = 1'b0;
  logic         rst_;
  logic [31:0]  pc_in;
  logic         pc_valid;
  logic         pc_ready;
  logic         flush;
  logic         icache_req;
  logic [31:0]  icache_addr;
  logic         icache_addr_ok;
  logic         icache_data_ok;
  logic [127:0] icache_rdata;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [31:0]  fetch_pc;
  logic [127:0] fetch_data;
  logic [2:0]   fetch_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] pend[$];
  logic [31:0] outq[$];
  logic [31:0] icq[$];
  int          cancel;

  if_fetch_ctrl #(
    .ADDR_W    (32),
    .DATA_W    (128),
    .MAX_OUTST (MO),
    .BUF_DEPTH (BD)
  ) dut (
    .clk            (clk),
    .rst_           (rst_),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_addr_ok (icache_addr_ok),
    .icache_data_ok (icache_data_ok),
    .icache_rdata   (icache_rdata),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_data     (fetch_data),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mkdata(
    input logic [31:0] pc
  );
    return {pc, ~pc, pc ^ 32'h5A5A_5A5A,
            32'h0000_000A};
  endfunction

  task automatic chk(
    input string         tag,
    input logic [159:0]  obs,
    input logic [159:0]  exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    pc_valid       = 1'b0;
    pc_in          = '0;
    flush          = 1'b0;
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b0;
    fetch_ready    = 1'b0;
  endtask

  task automatic model_clear();
    pend.delete();
    outq.delete();
    icq.delete();
    cancel = 0;
  endtask

  // One clock: check outputs against the reference, then advance both.
  task automatic cycle(input string tag);
    bit          req_e;
    bit          fv_e;
    bit          act_hs;
    logic [31:0] hp;
    if (icache_data_ok && icq.size() == 0)
      icache_data_ok = 1'b0;
    icache_rdata = (icq.size() != 0)
                 ? mkdata(icq[0]) : '0;
    #1;
    req_e = pc_valid && !flush && cancel == 0
         && pend.size() < MO
         && (pend.size() + outq.size()) < BD;
    fv_e  = (outq.size() != 0);
    chk({tag, ".req"}, icache_req, req_e);
    chk({tag, ".pc_ready"}, pc_ready,
        req_e && icache_addr_ok);
    chk({tag, ".addr"}, icache_addr, pc_in);
    chk({tag, ".fv"}, fetch_valid, fv_e);
    if (fv_e) begin
      hp = outq[0];
      chk({tag, ".fpc"}, fetch_pc, hp);
      chk({tag, ".fdata"}, fetch_data, mkdata(hp));
      chk({tag, ".fcnt"}, fetch_cnt,
          3'(4 - hp[3:2]));
    end
    act_hs = icache_req && icache_addr_ok;
    if (icache_data_ok) void'(icq.pop_front());
    if (act_hs) icq.push_back(pc_in);
    if (flush) begin
      cancel = cancel + pend.size()
             - (icache_data_ok ? 1 : 0);
      pend.delete();
      outq.delete();
    end else begin
      if (fv_e && fetch_ready)
        void'(outq.pop_front());
      if (icache_data_ok) begin
        if (cancel > 0) cancel--;
        else if (pend.size() != 0)
          outq.push_back(pend.pop_front());
      end
      if (req_e && icache_addr_ok)
        pend.push_back(pc_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc);
    pc_valid       = 1'b1;
    pc_in          = pc;
    icache_addr_ok = 1'b1;
    cycle("issue");
    pc_valid       = 1'b0;
  endtask

  initial begin
    idle_in();
    model_clear();
    icache_rdata = '0;

    // Reset: outputs low even with a valid PC pending.
    rst_     = 1'b1;
    pc_valid = 1'b1;
    pc_in    = 32'h0000_1234;
    icache_addr_ok = 1'b1;
    #3;
    chk("rst.req", icache_req, 1'b0);
    chk("rst.pc_ready", pc_ready, 1'b0);
    chk("rst.fv", fetch_valid, 1'b0);
    chk("rst.fcnt", fetch_cnt, 3'd4);
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b0;
    idle_in();

    // 1: single fetch, one-cycle response latency
    issue(32'hBFC0_0000);
    icache_data_ok = 1'b1;
    cycle("t1.resp");
    icache_data_ok = 1'b0;
    chk("t1.fv", fetch_valid, 1'b1);
    chk("t1.fpc", fetch_pc, 32'hBFC0_0000);
    chk("t1.fcnt", fetch_cnt, 3'd4);
    fetch_ready = 1'b1;
    cycle("t1.pop");
    fetch_ready = 1'b0;

    // 2: two in flight, third PC stalls on credit
    issue(32'h0000_0100);
    issue(32'h0000_0114);
    pc_valid       = 1'b1;
    pc_in          = 32'h0000_0128;
    icache_addr_ok = 1'b1;
    #1;
    chk("t2.stall", pc_ready, 1'b0);
    cycle("t2.stall");
    pc_valid       = 1'b0;
    icache_data_ok = 1'b1;
    cycle("t2.resp0");
    cycle("t2.resp1");
    icache_data_ok = 1'b0;
    chk("t2.cnt0", fetch_cnt, 3'd4);
    fetch_ready = 1'b1;
    cycle("t2.pop0");
    chk("t2.cnt1", fetch_cnt, 3'd3);
    chk("t2.pc1", fetch_pc, 32'h0000_0114);
    cycle("t2.pop1");
    fetch_ready = 1'b0;

    // 3: flush with two in flight, drain, then reissue
    issue(32'h0000_0300);
    issue(32'h0000_0310);
    flush    = 1'b1;
    pc_valid = 1'b1;
    pc_in    = 32'h0000_0200;
    icache_addr_ok = 1'b1;
    cycle("t3.flush");
    flush = 1'b0;
    chk("t3.cancel", dut.cancel_cnt, 2'd2);
    chk("t3.state", dut.state, DRAIN);
    icache_data_ok = 1'b1;
    cycle("t3.drop0");
    cycle("t3.drop1");
    icache_data_ok = 1'b0;
    chk("t3.state_idle", dut.state, IDLE);
    chk("t3.reissue", icache_req, 1'b1);
    cycle("t3.issue");
    pc_valid       = 1'b0;
    icache_data_ok = 1'b1;
    cycle("t3.resp");
    icache_data_ok = 1'b0;
    chk("t3.fpc", fetch_pc, 32'h0000_0200);
    fetch_ready = 1'b1;
    cycle("t3.pop");
    fetch_ready = 1'b0;

    // 4: flush coinciding with a response
    issue(32'h0000_0500);
    issue(32'h0000_0504);
    flush          = 1'b1;
    icache_data_ok = 1'b1;
    cycle("t4.flush");
    flush = 1'b0;
    chk("t4.cancel", dut.cancel_cnt, 2'd1);
    chk("t4.fv0", fetch_valid, 1'b0);
    cycle("t4.drop");
    icache_data_ok = 1'b0;
    chk("t4.fv1", fetch_valid, 1'b0);
    cycle("t4.idle");

    // 5: flush with a full packet buffer
    issue(32'h0000_0600);
    issue(32'h0000_0608);
    icache_data_ok = 1'b1;
    cycle("t5.resp0");
    cycle("t5.resp1");
    icache_data_ok = 1'b0;
    chk("t5.full", fetch_valid, 1'b1);
    flush       = 1'b1;
    fetch_ready = 1'b1;
    cycle("t5.flush");
    flush = 1'b0;
    chk("t5.empty", fetch_valid, 1'b0);
    cycle("t5.idle0");
    cycle("t5.idle1");
    fetch_ready = 1'b0;

    // 6: asynchronous reset while draining
    issue(32'h0000_0700);
    issue(32'h0000_0704);
    flush = 1'b1;
    cycle("t6.flush");
    flush = 1'b0;
    chk("t6.cancel", dut.cancel_cnt, 2'd2);
    pc_valid       = 1'b1;
    pc_in          = 32'h0000_0710;
    icache_addr_ok = 1'b1;
    rst_           = 1'b1;
    #1;
    chk("t6.req", icache_req, 1'b0);
    chk("t6.pc_ready", pc_ready, 1'b0);
    chk("t6.fv", fetch_valid, 1'b0);
    chk("t6.cancel0", dut.cancel_cnt, 2'd0);
    chk("t6.state", dut.state, IDLE);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    idle_in();
    model_clear();
    issue(32'h0000_040C);
    icache_data_ok = 1'b1;
    cycle("t6.resp");
    icache_data_ok = 1'b0;
    chk("t6.fpc", fetch_pc, 32'h0000_040C);
    chk("t6.fcnt", fetch_cnt, 3'd1);
    fetch_ready = 1'b1;
    cycle("t6.pop");

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      pc_valid       = ($urandom_range(0, 3) != 0);
      pc_in          = $urandom & 32'hFFFF_FFFC;
      icache_addr_ok = ($urandom_range(0, 3) != 0);
      icache_data_ok = ($urandom_range(0, 1) != 0);
      flush          = ($urandom_range(0, 24) == 0);
      fetch_ready    = ($urandom_range(0, 2) != 0);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
